// File: rtl/isa_write_decoder_if.sv
// ISA I/O write bus bundle: raw asynchronous ISA inputs in one direction,
// captured data, load strobes and busy flag in the other.
interface isa_write_decoder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [9:0]            isa_addr;
    logic [DATA_WIDTH-1:0] isa_data;
    logic                  isa_iow_n;
    logic                  isa_aen;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            load_n;
    logic                  busy;

    // The ISA side of the bus (bench or bus bridge) drives the raw inputs.
    modport master (
        output isa_addr, isa_data, isa_iow_n, isa_aen,
        input  wr_data, load_n, busy
    );

    // The decoder consumes the raw inputs and produces the register-file strobes.
    modport slave (
        input  isa_addr, isa_data, isa_iow_n, isa_aen,
        output wr_data, load_n, busy
    );
endinterface

// File: rtl/isa_write_decoder.sv
// ISA I/O write front-end: synchronises IOW#, address, data and AEN into clk,
// glitch-filters IOW#, decodes a 4-port window at BASE_ADDR and issues one
// active-low one-hot load strobe per qualified write.
module isa_write_decoder #(
    parameter logic [9:0] BASE_ADDR  = 10'h220,
    parameter int         DATA_WIDTH = 8,
    parameter int         FILTER     = 2
) (
    input  logic            clk,
    input  logic            reset,
    isa_write_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_QUALIFY,
        S_CHECK,
        S_STROBE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] FILTER_CNT = 4'(FILTER);

    logic                  r_iowMeta;
    logic                  r_iowS;
    logic [9:0]            r_addrMeta;
    logic [9:0]            r_addrS;
    logic [DATA_WIDTH-1:0] r_dataMeta;
    logic [DATA_WIDTH-1:0] r_dataS;
    logic                  r_aenMeta;
    logic                  r_aenS;
    logic [1:0]            r_syncValid;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic [1:0]            r_sel;

    state_t                w_stateNext;
    logic [3:0]            w_cntNext;
    logic [DATA_WIDTH-1:0] w_wrDataNext;
    logic [1:0]            w_selNext;
    logic                  w_hit;

    // Two-flop synchronisers; r_syncValid marks when the chain holds real samples
    // rather than its reset values, so ARM cannot mistake the reset-value high
    // for a released IOW# while the raw strobe is still low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iowMeta   <= 1'b1;
            r_iowS      <= 1'b1;
            r_addrMeta  <= '0;
            r_addrS     <= '0;
            r_dataMeta  <= '0;
            r_dataS     <= '0;
            r_aenMeta   <= 1'b0;
            r_aenS      <= 1'b0;
            r_syncValid <= 2'b00;
        end else begin
            r_iowMeta   <= bus.isa_iow_n;
            r_iowS      <= r_iowMeta;
            r_addrMeta  <= bus.isa_addr;
            r_addrS     <= r_addrMeta;
            r_dataMeta  <= bus.isa_data;
            r_dataS     <= r_dataMeta;
            r_aenMeta   <= bus.isa_aen;
            r_aenS      <= r_aenMeta;
            r_syncValid <= {r_syncValid[0], 1'b1};
        end
    end

    assign w_hit = !r_aenS && (r_addrS[9:2] == BASE_ADDR[9:2]);

    // Next-state logic: filter count, decode, and capture of data and port select.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_wrDataNext = r_wrData;
        w_selNext    = r_sel;
        case (r_state)
            S_ARM: begin
                if (r_syncValid[1] && r_iowS) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!r_iowS) begin
                    w_cntNext   = 4'd1;
                    w_stateNext = (FILTER == 1) ? S_CHECK : S_QUALIFY;
                end
            end
            S_QUALIFY: begin
                if (r_iowS) begin
                    w_stateNext = S_IDLE;
                end else begin
                    w_cntNext = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == FILTER_CNT) begin
                        w_stateNext = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_hit) begin
                    w_wrDataNext = r_dataS;
                    w_selNext    = r_addrS[1:0];
                    w_stateNext  = S_STROBE;
                end else begin
                    w_stateNext = S_RELEASE;
                end
            end
            S_STROBE: begin
                w_stateNext = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_iowS) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_ARM;
            end
        endcase
    end

    // State register with synchronous reset taking priority over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_ARM;
            r_cnt    <= 4'd0;
            r_wrData <= '0;
            r_sel    <= 2'd0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_wrData <= w_wrDataNext;
            r_sel    <= w_selNext;
        end
    end

    assign bus.wr_data = r_wrData;
    assign bus.load_n  = (r_state == S_STROBE) ? ~(4'b0001 << r_sel) : 4'b1111;
    assign bus.busy    = (r_state != S_ARM) && (r_state != S_IDLE);

endmodule

// File: tb/tb_isa_write_decoder.sv
// Self-checking bench for isa_write_decoder: directed writes, decode rejects,
// glitches, long and back-to-back strobes, resets mid-operation, plus random
// writes compared against a transaction-level model of the decoder.
module tb_isa_write_decoder;

    localparam logic [9:0] BASE_ADDR  = 10'h220;
    localparam int         DATA_WIDTH = 8;
    localparam int         FILTER     = 2;

    typedef struct {
        int                    cycle;
        logic [3:0]            loadN;
        logic [DATA_WIDTH-1:0] wrData;
    } strobe_t;

    logic clk = 1'b0;
    logic reset;

    isa_write_decoder_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    isa_write_decoder #(
        .BASE_ADDR  (BASE_ADDR),
        .DATA_WIDTH (DATA_WIDTH),
        .FILTER     (FILTER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz bench clock.
    always #5 clk = ~clk;

    int                    checks = 0;
    int                    errors = 0;
    int                    cyc    = 0;
    strobe_t               strobes[$];
    logic [DATA_WIDTH-1:0] modelWr = '0;

    // One comparison point: counts it and reports tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, sample just after the edge and log any active strobe.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.load_n !== 4'b1111) begin
            strobes.push_back('{cyc, bus.load_n, bus.wr_data});
        end
    endtask

    // Drive one ISA write (raw IOW# low for lowCycles, then high for highCycles)
    // and compare what the DUT did against the transaction model.
    task automatic applyStimulus(input logic [9:0] addr, input logic [DATA_WIDTH-1:0] data,
                                 input logic aen, input int lowCycles, input int highCycles,
                                 input string tag);
        int         startCyc;
        bit         hit;
        bit         qualified;
        logic [3:0] expLoad;
        strobes.delete();
        bus.isa_addr  = addr;
        bus.isa_data  = data;
        bus.isa_aen   = aen;
        bus.isa_iow_n = 1'b0;
        startCyc      = cyc;
        repeat (lowCycles) stepCycle();
        bus.isa_iow_n = 1'b1;
        repeat (highCycles) stepCycle();

        hit       = (aen == 1'b0) && ((int'(addr) / 4) == (int'(BASE_ADDR) / 4));
        qualified = (lowCycles >= FILTER);
        checkOutput({tag, " strobe count"}, strobes.size(), (hit && qualified) ? 1 : 0);
        if (hit && qualified) begin
            modelWr = data;
            expLoad = 4'(15 - (1 << (int'(addr) % 4)));
            if (strobes.size() > 0) begin
                checkOutput({tag, " strobe latency"}, strobes[0].cycle - startCyc, FILTER + 3);
                checkOutput({tag, " load_n"}, strobes[0].loadN, expLoad);
                checkOutput({tag, " wr_data at strobe"}, strobes[0].wrData, data);
            end
        end
        checkOutput({tag, " wr_data held"}, bus.wr_data, modelWr);
        if (highCycles >= 6) begin
            checkOutput({tag, " busy idle"}, bus.busy, 1'b0);
        end
    endtask

    initial begin
        logic [9:0]            rAddr;
        logic [DATA_WIDTH-1:0] rData;
        logic                  rAen;
        int                    rLow;

        reset         = 1'b1;
        bus.isa_addr  = '0;
        bus.isa_data  = '0;
        bus.isa_aen   = 1'b0;
        bus.isa_iow_n = 1'b1;
        $display("[TB] reset with IOW# high");
        repeat (3) stepCycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("reset load_n", bus.load_n, 4'b1111);
            checkOutput("reset wr_data", bus.wr_data, '0);
            checkOutput("reset busy", bus.busy, 1'b0);
        end

        $display("[TB] basic writes across the window");
        applyStimulus(10'h222, 8'hA5, 1'b0, 10, 6, "write 222");
        applyStimulus(10'h220, 8'h11, 1'b0, 10, 6, "write 220");
        applyStimulus(10'h221, 8'h22, 1'b0, 10, 6, "write 221");
        applyStimulus(10'h223, 8'h33, 1'b0, 10, 6, "write 223");

        $display("[TB] decode rejects");
        applyStimulus(10'h224, 8'hEE, 1'b0, 10, 6, "miss 224");
        applyStimulus(10'h222, 8'hDD, 1'b1, 10, 6, "aen 222");

        $display("[TB] glitch rejection");
        applyStimulus(10'h222, 8'h5F, 1'b0, 1, 6, "glitch 1");
        applyStimulus(10'h221, 8'h6E, 1'b0, 3, 6, "pulse 3");

        $display("[TB] long strobe then back-to-back write");
        applyStimulus(10'h220, 8'h81, 1'b0, 100, 1, "long 100");
        applyStimulus(10'h223, 8'h3C, 1'b0, 10, 6, "back-to-back");

        $display("[TB] reset during STROBE and release with IOW# low");
        strobes.delete();
        bus.isa_addr  = 10'h221;
        bus.isa_data  = 8'h77;
        bus.isa_aen   = 1'b0;
        bus.isa_iow_n = 1'b0;
        repeat (FILTER + 3) stepCycle();
        checkOutput("pre-reset load_n", bus.load_n, 4'b1101);
        checkOutput("pre-reset wr_data", bus.wr_data, 8'h77);
        reset = 1'b1;
        stepCycle();
        checkOutput("reset cuts strobe", bus.load_n, 4'b1111);
        checkOutput("reset clears wr_data", bus.wr_data, '0);
        checkOutput("reset busy", bus.busy, 1'b0);
        modelWr = '0;
        stepCycle();
        reset = 1'b0;
        strobes.delete();
        repeat (12) stepCycle();
        checkOutput("armed no strobe", strobes.size(), 0);
        checkOutput("armed busy", bus.busy, 1'b0);
        bus.isa_iow_n = 1'b1;
        repeat (4) stepCycle();
        applyStimulus(10'h223, 8'h5A, 1'b0, 10, 6, "post-reset write");

        $display("[TB] random writes");
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                rAddr = 10'($urandom);
            end else begin
                rAddr = 10'(int'(BASE_ADDR) + int'($urandom_range(0, 7)));
            end
            rData = DATA_WIDTH'($urandom);
            rAen  = ($urandom_range(0, 3) == 0);
            rLow  = int'($urandom_range(1, 6));
            applyStimulus(rAddr, rData, rAen, rLow, 6, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isa_write_decoder.md
# isa_write_decoder

ISA I/O write front-end for the riser's register file. Synchronises the asynchronous ISA `IOW#` strobe into `clk`, glitch-filters it, and decodes the I/O address against a 4-port window. On a qualified write it presents the captured data byte and a one-cycle, active-low, one-hot load strobe to the downstream `Register` instances, which sample `D` on the rising `clk` edge while their `load` input is low.

## Interface
- `BASE_ADDR`, 10'h220: window base. Must be 4-aligned; bits [1:0] are ignored.
- `DATA_WIDTH`, 8: width of `isa_data` and `wr_data`.
- `FILTER`, 2: consecutive low samples of synchronised `IOW#` required to qualify a write. Legal range is 1..15.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `isa_addr` input 10: ISA SA[9:0]. Asynchronous.
- `isa_data` input DATA_WIDTH: ISA SD bus. Asynchronous.
- `isa_iow_n` input 1: ISA `IOW#`. Asynchronous, active-low.
- `isa_aen` input 1: ISA AEN. When high, marks a DMA cycle that must be ignored.
- `wr_data` output DATA_WIDTH: captured write data, driven to `Register.D`.
- `load_n` output 4: one-hot, active-low load strobes. Bit k addresses `BASE_ADDR+k`.
- `busy` output 1: high in any state except ARM and IDLE.

## Operation
- **Synchronisation.** `isa_iow_n`, `isa_addr`, `isa_data` and `isa_aen` pass through two flop stages each. The second stage outputs are `iow_s`, `addr_s`, `data_s` and `aen_s`. All decisions below use only these synchronised signals.
- **States.**
  - ARM: wait for `iow_s`=1, then go to IDLE. Prevents capture of a strobe already in progress at reset release.
  - IDLE: when `iow_s`=0, load `cnt`=1. If FILTER=1, go to CHECK; otherwise go to QUALIFY.
  - QUALIFY:
    - If `iow_s`=1, go to IDLE (glitch rejected, no strobe).
    - Else increment `cnt`. When `cnt` reaches FILTER, go to CHECK.
  - CHECK (one cycle):
    - On a hit, register `wr_data`←`data_s` and `sel`←`addr_s[1:0]`, then go to STROBE.
    - On a miss, go to RELEASE.
    - Hit condition: `aen_s`=0 and `addr_s[9:2]`==`BASE_ADDR[9:2]`.
  - STROBE (one cycle): `load_n[sel]`=0, all other bits 1. Go to RELEASE.
  - RELEASE: wait for `iow_s`=1, then go to IDLE. This gives one strobe per `IOW#` assertion regardless of its length.
- **Held outputs.** `wr_data` holds its value until the next hit; it does not change on a miss. `load_n` is 4'b1111 in every state except STROBE.
- **Reset.**
  - Effect: state=ARM, `cnt`=0, `wr_data`=0, `sel`=0, `load_n`=4'b1111, `busy`=0, all sync flops=1 (iow) or 0 (others).
  - Reset has priority over every transition. Asserted during STROBE, it forces `load_n` to 4'b1111 in the next cycle.
- **`IOW#` rising during CHECK or STROBE.** The strobe still completes. RELEASE then exits on the next cycle.

## Timing
- **Cycle numbering.** Cycle n is the first cycle with `iow_s`=0 while in IDLE. Raw `isa_iow_n` low is first sampled 2 edges earlier.
- **FILTER=2:**
  - n+1: QUALIFY.
  - n+2: CHECK.
  - n+3: STROBE, with `load_n` low for exactly one cycle.
  - The downstream `Register` loads at the edge ending n+3.
- **General latency.** Raw `IOW#` falling to `load_n` low is FILTER+3 cycles (±1 for synchroniser phase).
- **Setup margin.** `wr_data` is stable from the start of STROBE, giving at least one full cycle of setup before the downstream load edge.
- **ISA constraints.** Address and data must be stable for at least FILTER+3 `clk` periods after `IOW#` falls. With the 50 MHz `clk` and the ISA minimum write pulse, FILTER ≤ 5.
- **Minimum spacing.** Two writes need `iow_s` high for at least one cycle between them.

## Test plan
- **Reset.** Assert `reset` for 3 cycles with `isa_iow_n`=1 → `load_n`=4'b1111, `wr_data`=0, `busy`=0. Hold these for 10 cycles after release.
- **Basic write.** BASE_ADDR=0x220; write 0xA5 to 0x222 with `IOW#` low for 10 cycles → `load_n`=4'b1011 for exactly one cycle at FILTER+3 after the falling edge, and `wr_data`=0xA5. Repeat for 0x220, 0x221 and 0x223 → bits 0, 1 and 3 respectively.
- **Decode rejects.**
  - Write to 0x224 → no strobe, `wr_data` unchanged.
  - Write to 0x222 with `isa_aen`=1 → no strobe.
- **Glitch rejection.** FILTER=2; `IOW#` low for 1 `clk` cycle → no strobe and `busy` returns to 0. A low of 3 cycles → exactly one strobe.
- **Long strobe and back-to-back writes.** `IOW#` low for 100 cycles → exactly one strobe. Then high for 1 synchronised cycle and low again writing 0x3C → a second strobe with `wr_data`=0x3C.
- **Reset mid-operation.**
  - Assert `reset` during STROBE → `load_n`=4'b1111 the next cycle.
  - Release `reset` while `isa_iow_n`=0 → no strobe until `IOW#` goes high and low again.
